// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional BNE support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_BNE   = 6'h05
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op
);

`ifdef MIPS_MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl_q;
    logic   is_bne;
    logic   branch_taken;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:   n = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)      n = S_MEMADR;
                else if (op == OP_RTYPE)             n = S_EXECUTE;
                else if (op == OP_BEQ)               n = S_BRANCH;
                else if (BNE_EN && op == OP_BNE)     n = S_BRANCH;
                else if (op == OP_ADDI)              n = S_ADDIEX;
                else if (op == OP_J)                 n = S_JUMP;
                else                                 n = S_FETCH;
            end
            S_MEMADR:  n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   n = S_MEMWB;
            S_EXECUTE: n = S_ALUWB;
            S_ADDIEX:  n = S_ADDIWB;
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    // Outputs are registered with the state they belong to, so they line up with state exactly.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_en     = 1'b1;
            end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB:  c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src = 2'b10;
                c.pc_en  = 1'b1;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= next_state(state, opcode);
            ctrl_q <= state_ctrl(next_state(state, opcode));
        end
    end

    assign is_bne       = BNE_EN && (opcode == OP_BNE);
    assign branch_taken = is_bne ? ~zero : zero;

    assign iord       = ctrl_q.iord;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    // Branch resolution and opcode legality depend on live inputs, so they bypass the output register.
    assign pc_en      = ctrl_q.pc_en | ((state == S_BRANCH) & branch_taken);
    assign illegal_op = (state == S_DECODE) &&
                        (next_state(S_DECODE, opcode) == S_FETCH);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control: walks each instruction class cycle by cycle.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_en, illegal_op;

    int checks = 0;
    int errors = 0;

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Order: iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b alu_op pc_src pc_en illegal_op
    function automatic logic [14:0] v(input bit io, input bit mw, input bit irw, input bit rd,
                                      input bit mtr, input bit rw, input bit asa,
                                      input bit [1:0] asb, input bit [1:0] aop,
                                      input bit [1:0] pcs, input bit pce, input bit ill);
        return {io, mw, irw, rd, mtr, rw, asa, asb, aop, pcs, pce, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] expv);
        logic [14:0] obs;
        obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_src, pc_en, illegal_op};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, expv);
        end
    endtask

    logic [14:0] e_fetch, e_decode, e_dec_ill, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [14:0] e_exec, e_aluwb, e_br_t, e_br_n, e_addiex, e_addiwb, e_jump;

    initial begin
        e_fetch   = v(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0);
        e_decode  = v(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        e_dec_ill = v(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
        e_memadr  = v(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        e_memrd   = v(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        e_memwb   = v(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
        e_memwr   = v(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        e_exec    = v(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
        e_aluwb   = v(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
        e_br_t    = v(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
        e_br_n    = v(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
        e_addiex  = v(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        e_addiwb  = v(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
        e_jump    = v(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);

        reset = 1'b1; opcode = 6'h3F; zero = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_fetch", e_fetch);

        // LW: 5 cycles
        opcode = 6'h23;
        tick(); chk("lw_decode", e_decode);
        tick(); chk("lw_memadr", e_memadr);
        tick(); chk("lw_memrd", e_memrd);
        tick(); chk("lw_memwb", e_memwb);
        tick(); chk("lw_fetch", e_fetch);

        // SW: 4 cycles
        opcode = 6'h2B;
        tick(); chk("sw_decode", e_decode);
        tick(); chk("sw_memadr", e_memadr);
        tick(); chk("sw_memwr", e_memwr);
        tick(); chk("sw_fetch", e_fetch);

        // R-type: 4 cycles
        opcode = 6'h00;
        tick(); chk("r_decode", e_decode);
        tick(); chk("r_exec", e_exec);
        tick(); chk("r_aluwb", e_aluwb);
        tick(); chk("r_fetch", e_fetch);

        // ADDI: 4 cycles
        opcode = 6'h08;
        tick(); chk("addi_decode", e_decode);
        tick(); chk("addi_ex", e_addiex);
        tick(); chk("addi_wb", e_addiwb);
        tick(); chk("addi_fetch", e_fetch);

        // BEQ taken, zero toggled inside BRANCH to exercise the live path
        opcode = 6'h04; zero = 1'b0;
        tick(); chk("beq_t_decode", e_decode);
        tick(); chk("beq_br_zero0", e_br_n);
        zero = 1'b1; #1;
        chk("beq_br_zero1", e_br_t);
        tick(); chk("beq_t_fetch", e_fetch);

        // BEQ not taken
        zero = 1'b0;
        tick(); chk("beq_n_decode", e_decode);
        tick(); chk("beq_n_branch", e_br_n);
        tick(); chk("beq_n_fetch", e_fetch);

        // J: 3 cycles
        opcode = 6'h02;
        tick(); chk("j_decode", e_decode);
        tick(); chk("j_jump", e_jump);
        tick(); chk("j_fetch", e_fetch);

        // Illegal opcode: 2 cycles
        opcode = 6'h3F;
        tick(); chk("ill_decode", e_dec_ill);
        tick(); chk("ill_fetch", e_fetch);

        // BNE: branch when the feature is built in, illegal otherwise
        opcode = 6'h05; zero = 1'b0;
`ifdef MIPS_MC_BNE_EN
        tick(); chk("bne_decode", e_decode);
        tick(); chk("bne_branch_z0", e_br_t);
        zero = 1'b1; #1;
        chk("bne_branch_z1", e_br_n);
        tick(); chk("bne_fetch", e_fetch);
`else
        tick(); chk("bne_decode_ill", e_dec_ill);
        tick(); chk("bne_fetch", e_fetch);
`endif

        // Reset mid-LW during MEMRD
        opcode = 6'h23; zero = 1'b0;
        tick(); chk("rst_lw_decode", e_decode);
        tick(); chk("rst_lw_memadr", e_memadr);
        tick(); chk("rst_lw_memrd", e_memrd);
        reset = 1'b1;
        tick(); chk("rst_mid_fetch", e_fetch);
        reset = 1'b0;
        tick(); chk("rst_after_decode", e_decode);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
